bsg_fifo_to_m_axi_lite: RTL
===========================

Name: bsg_fifo_to_m_axi_lite

Overview:
- AXI4-Lite master (initiator) driven by a valid/ready request stream; returns completions on a valid/yumi stream.
- Sits on the FPGA fabric side and issues register reads/writes into AXI-Lite slaves: PCIe-bridge CSRs, debug registers, and the slave FIFO bridge.
- One transaction outstanding at a time; all AXI outputs are registered.

Parameters:
- addr_width_p, 32, AXI address width.
- data_width_p, 32, AXI data width; must be 32 (wstrb is 4 bits).
- timeout_p, 1024, response watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  reset, asynchronous, active-low.
- v_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_p  request address.
- data_i  in  data_width_p  write data.
- wstrb_i  in  4  write byte strobes.
- ready_o  out  1  request accepted when v_i & ready_o.
- v_o  out  1  completion valid.
- we_o  out  1  completion type (echo of we_i).
- data_o  out  data_width_p  read data; 0 for writes.
- resp_o  out  2  AXI response code.
- yumi_i  in  1  completion consumed; legal only when v_o.
- awaddr_o  out  addr_width_p;  awprot_o  out  3;  awvalid_o  out  1;  awready_i  in  1.
- wdata_o  out  data_width_p;  wstrb_o  out  4;  wvalid_o  out  1;  wready_i  in  1.
- bresp_i  in  2;  bvalid_i  in  1;  bready_o  out  1.
- araddr_o  out  addr_width_p;  arprot_o  out  3;  arvalid_o  out  1;  arready_i  in  1.
- rdata_i  in  data_width_p;  rresp_i  in  2;  rvalid_i  in  1;  rready_o  out  1.

Behaviour:
- Reset (reset_i low, async) → state IDLE.
  - All *valid_o, bready_o, rready_o and v_o are 0.
  - Data/address registers are 0.
  - ready_o = 1 once out of reset.
- prot outputs are constant 3'b000.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - ready_o=1.
  - On v_i & we_i: latch addr/data/wstrb, assert awvalid_o and wvalid_o next cycle, go to WR_ADDR_DATA.
  - On v_i & ~we_i: latch addr, assert arvalid_o next cycle, go to RD_ADDR.
  - ready_o=0 in every other state.
- WR_ADDR_DATA:
  - awvalid_o drops the cycle after awvalid_o & awready_i; wvalid_o drops the cycle after wvalid_o & wready_i.
  - AW and W handshakes are independent and may complete in the same or different cycles; track each with a done flag.
  - When both are done, assert bready_o and go to WR_RESP. Same-cycle completion of both goes directly.
- WR_RESP: bready_o=1. On bvalid_i, capture bresp_i, set data_o=0, we_o=1, drop bready_o, go to DONE.
- RD_ADDR: arvalid_o held until arready_i; then drop arvalid_o, raise rready_o, go to RD_DATA.
- RD_DATA: rready_o=1. On rvalid_i, capture rdata_i/rresp_i, we_o=0, go to DONE.
- DONE: v_o=1 and completion held stable until yumi_i, then IDLE.
- Valid signals never drop before their handshake. Payloads stay stable while valid.
- Minimum latency, request accept to v_o, with slave ready always high:
  - write = 3 cycles (AW/W, B, v_o);
  - read = 3 cycles (AR, R, v_o).
- Back-to-back: a new request can be accepted the cycle after yumi_i. No combinational path from any input to ready_o or to AXI valids.
- Responses early relative to protocol (bvalid before AW/W done) are ignored, since bready_o=0. Any resp code, including 2'b10/2'b11, is passed through unmodified.
- Reset asserted mid-transaction aborts immediately to reset values. Any slave-side cleanup is the system's responsibility.

Optional Feature:
- Macro BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN.
- Defined:
  - A counter of width `BSG_SAFE_CLOG2(timeout_p+1) clears on entry to WR_ADDR_DATA or RD_ADDR and counts every non-DONE/non-IDLE cycle.
  - When it reaches timeout_p, complete with resp_o=2'b11 and data_o=32'hdeadbeef.
  - Drop aw/w/ar valids and keep bready_o/rready_o low. Set the sticky output timeout_o (1 bit, cleared only by reset).
  - The block then refuses new requests (ready_o=0) until reset.
- Undefined: no counter, no timeout_o port; the block waits indefinitely.

Decomposition:
- Shared package bsg_axi_lite_pkg:
  - resp typedef/enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - FSM state enum;
  - prot constant.
- No sub-module required. The watchdog fits inline.
- Optional sub-module bsg_axi_lite_aw_w_tracker for the dual-handshake done flags.

Test Plan:
- Write addr=0x10, data=0xCAFEF00D, wstrb=0xF, slave readies always 1, bresp=0 → awaddr_o=0x10, wdata_o=0xCAFEF00D, v_o after 3 cycles, we_o=1, resp_o=0.
- Write with awready delayed 4 cycles, wready immediate → wvalid_o drops after 1 cycle, awvalid_o held 4 cycles, bready_o rises only after both handshakes.
- Read addr=0x0, rdata=0x00000005, rresp=0, rvalid delayed 2 cycles → data_o=0x5, we_o=0, ready_o=0 throughout until yumi_i.
- Completion held 5 cycles with yumi_i=0 → v_o/data_o stable, no AXI valid asserted, ready_o=0; yumi_i=1 then new request accepted next cycle.
- Read returning rresp=2'b10 → resp_o=2'b10, data passed through.
- Reset pulsed low during WR_RESP → all valids and readies 0 immediately, ready_o=1 after release. With the macro and timeout_p=16 and no bvalid: resp_o=2'b11 at cycle 16, timeout_o=1.

Source files
------------

// File: rtl/bsg_axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states, fixed constants.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bsg_axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  // Unprivileged, secure, data access for every transaction
  localparam logic [2:0]  axi_prot_c     = 3'b000;
  // Read data reported when the watchdog abandons a transaction
  localparam logic [31:0] timeout_data_c = 32'hdeadbeef;

  // clog2 that never returns 0, so a counter is at least one bit wide
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_fifo_to_m_axi_lite.sv
// AXI4-Lite master: one request at a time from a valid/ready stream, completion on valid/yumi.
// Latency: 3 cycles accept-to-v_o for read or write when the slave is always ready.
// Backpressure: ready_o only in IDLE; completion held until yumi_i. Watchdog: BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN.
module bsg_fifo_to_m_axi_lite
  import bsg_axi_lite_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
  // watchdog limit exists only when the watchdog is built
  , parameter int timeout_p = 1024
`endif
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic                    we_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [3:0]              wstrb_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic                    we_o,
  output logic [data_width_p-1:0] data_o,
  output logic [1:0]              resp_o,
  input  logic                    yumi_i,
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
  output logic                    timeout_o,
`endif
  output logic [addr_width_p-1:0] awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [data_width_p-1:0] wdata_o,
  output logic [3:0]              wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [addr_width_p-1:0] araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [data_width_p-1:0] rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  state_e                  state_r, state_n;
  logic                    aw_done_r, aw_done_n, w_done_r, w_done_n;
  logic                    awvalid_r, awvalid_n, wvalid_r, wvalid_n, arvalid_r, arvalid_n;
  logic                    bready_r, bready_n, rready_r, rready_n;
  logic                    v_r, v_n, we_r, we_n;
  logic [addr_width_p-1:0] addr_r, addr_n;
  logic [data_width_p-1:0] wdata_r, wdata_n, data_r, data_n;
  logic [3:0]              wstrb_r, wstrb_n;
  logic [1:0]              resp_r, resp_n;
  logic                    aw_fire, w_fire, accept;

  assign aw_fire = awvalid_r & awready_i;
  assign w_fire  = wvalid_r & wready_i;
  assign accept  = v_i & ready_o;

`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
  localparam int cnt_w_lp = safe_clog2(timeout_p + 1);
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic                timeout_r, timeout_n;
  logic                busy;
  assign busy      = (state_r != IDLE) && (state_r != DONE);
  // ready depends only on registered state, never combinationally on an input
  assign ready_o   = (state_r == IDLE) & ~timeout_r;
  assign timeout_o = timeout_r;
`else
  assign ready_o   = (state_r == IDLE);
`endif

  assign awaddr_o  = addr_r;
  assign araddr_o  = addr_r;
  assign awprot_o  = axi_prot_c;
  assign arprot_o  = axi_prot_c;
  assign awvalid_o = awvalid_r;
  assign wdata_o   = wdata_r;
  assign wstrb_o   = wstrb_r;
  assign wvalid_o  = wvalid_r;
  assign bready_o  = bready_r;
  assign arvalid_o = arvalid_r;
  assign rready_o  = rready_r;
  assign v_o       = v_r;
  assign we_o      = we_r;
  assign data_o    = data_r;
  assign resp_o    = resp_r;

  // Next state and next value of every registered output
  always_comb begin
    state_n   = state_r;
    aw_done_n = aw_done_r;
    w_done_n  = w_done_r;
    awvalid_n = awvalid_r;
    wvalid_n  = wvalid_r;
    arvalid_n = arvalid_r;
    bready_n  = bready_r;
    rready_n  = rready_r;
    v_n       = v_r;
    we_n      = we_r;
    addr_n    = addr_r;
    wdata_n   = wdata_r;
    wstrb_n   = wstrb_r;
    data_n    = data_r;
    resp_n    = resp_r;
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
    cnt_n     = cnt_r;
    timeout_n = timeout_r;
`endif
    case (state_r)
      IDLE: if (accept) begin
        addr_n = addr_i;
        we_n   = we_i;
        if (we_i) begin
          wdata_n   = data_i;
          wstrb_n   = wstrb_i;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = WR_ADDR_DATA;
        end else begin
          arvalid_n = 1'b1;
          state_n   = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; each valid drops after its own handshake
        aw_done_n = aw_done_r | aw_fire;
        w_done_n  = w_done_r | w_fire;
        awvalid_n = awvalid_r & ~aw_fire;
        wvalid_n  = wvalid_r & ~w_fire;
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: if (bvalid_i) begin
        resp_n   = bresp_i;
        data_n   = '0;
        we_n     = 1'b1;
        bready_n = 1'b0;
        v_n      = 1'b1;
        state_n  = DONE;
      end
      RD_ADDR: if (arready_i) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (rvalid_i) begin
        data_n   = rdata_i;
        resp_n   = rresp_i;
        we_n     = 1'b0;
        rready_n = 1'b0;
        v_n      = 1'b1;
        state_n  = DONE;
      end
      DONE: if (yumi_i) begin
        v_n     = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
    // A real completion in the final watchdog cycle wins over the timeout
    if (accept) begin
      cnt_n = '0;
    end else if (busy) begin
      if ((cnt_r == cnt_w_lp'(timeout_p - 1)) && (state_n != DONE)) begin
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        arvalid_n = 1'b0;
        bready_n  = 1'b0;
        rready_n  = 1'b0;
        data_n    = timeout_data_c;
        resp_n    = RESP_DECERR;
        v_n       = 1'b1;
        timeout_n = 1'b1;
        state_n   = DONE;
      end else begin
        cnt_n = cnt_r + cnt_w_lp'(1);
      end
    end
`endif
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r   <= IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      arvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      rready_r  <= 1'b0;
      v_r       <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      data_r    <= '0;
      resp_r    <= '0;
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
      cnt_r     <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      aw_done_r <= aw_done_n;
      w_done_r  <= w_done_n;
      awvalid_r <= awvalid_n;
      wvalid_r  <= wvalid_n;
      arvalid_r <= arvalid_n;
      bready_r  <= bready_n;
      rready_r  <= rready_n;
      v_r       <= v_n;
      we_r      <= we_n;
      addr_r    <= addr_n;
      wdata_r   <= wdata_n;
      wstrb_r   <= wstrb_n;
      data_r    <= data_n;
      resp_r    <= resp_n;
`ifdef BSG_FIFO_TO_M_AXI_LITE_TIMEOUT_EN
      cnt_r     <= cnt_n;
      timeout_r <= timeout_n;
`endif
    end
  end

endmodule
